// File: rtl/rfsoc_config.sv
// Shared configuration for the RFSoC DAC sequencer: serial GPIO bit map,
// default widths and the types used between the sequencer pipeline stages.
package rfsoc_config;

    localparam int unsigned GPIO_W = 16;

    localparam int unsigned SDATA_BIT                = 0;
    localparam int unsigned MUX_SET_CLK_BIT          = 1;
    localparam int unsigned CYCLE_COUNT_CLK_BIT      = 2;
    localparam int unsigned MASK_CLK_BIT             = 3;
    localparam int unsigned DELAY_CYCLE_CLK_BIT      = 4;
    localparam int unsigned LOCKING_WAVEFORM_CLK_BIT = 5;

    localparam int unsigned DEF_SAMPLE_W = 16;
    localparam int unsigned DEF_LANES    = 16;
    localparam int unsigned DEF_DEPTH    = 1024;
    localparam int unsigned DEF_CFG_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PLAY  = 2'd2
    } seq_state_t;

    // Side-band tag that follows a memory read down the output pipeline.
    typedef struct packed {
        logic play;
        logic mark;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/serial_cfg_reg.sv
// One serially loaded config register: two-flop synchroniser on the serial
// clock/data pair, gated rising-edge detect, and an LSB-first shift register.
module serial_cfg_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             select_in,
    input  logic             sclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] value
);

    logic [1:0] sclk_sync;
    logic [1:0] sdata_sync;
    logic       sclk_prev;
    logic       rise_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync  <= '0;
            sdata_sync <= '0;
            sclk_prev  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[0], sclk};
            sdata_sync <= {sdata_sync[0], sdata};
            sclk_prev  <= sclk_sync[1];
        end
    end

    // Edges seen while deselected are consumed, not deferred.
    assign rise_c = sclk_sync[1] & ~sclk_prev & select_in;

    generate
        if (WIDTH == 1) begin : g_bit
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    value <= '0;
                end else if (rise_c) begin
                    value <= sdata_sync[1];
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    value <= '0;
                end else if (rise_c) begin
                    value <= {sdata_sync[1], value[WIDTH-1:1]};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dac_seq_driver.sv
// Multi-word DAC waveform sequencer: AXIS load into RAM, triggered delayed
// playback (finite or continuous) blended with a locking waveform via a mask.
module dac_seq_driver
    import rfsoc_config::*;
#(
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
    parameter int unsigned LANES    = DEF_LANES,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned CFG_W    = DEF_CFG_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [GPIO_W-1:0]         gpio_ctrl,
    input  logic                      select_in,
    output logic [SAMPLE_W*LANES-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    input  logic [SAMPLE_W*LANES-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      trigger_in,
    output logic                      playing,
    output logic                      cycle_mark,
    output logic                      done,
    output logic [$clog2(DEPTH):0]    load_count
);

    localparam int unsigned W  = SAMPLE_W * LANES;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic             mux_sel;
    logic [CFG_W-1:0] cycle_count;
    logic [CFG_W-1:0] delay;
    logic [W-1:0]     mask;
    logic [W-1:0]     lock_wave;

    // DAC is always ready; upper GPIO bits are spare.
    logic unused_ok;
    assign unused_ok = ^{gpio_ctrl, m_axis_tready};

    serial_cfg_reg #(.WIDTH(1)) u_mux_sel (
        .clk(clk), .rst(rst), .select_in(select_in),
        .sclk(gpio_ctrl[MUX_SET_CLK_BIT]), .sdata(gpio_ctrl[SDATA_BIT]),
        .value(mux_sel)
    );

    serial_cfg_reg #(.WIDTH(CFG_W)) u_cycle_count (
        .clk(clk), .rst(rst), .select_in(select_in),
        .sclk(gpio_ctrl[CYCLE_COUNT_CLK_BIT]), .sdata(gpio_ctrl[SDATA_BIT]),
        .value(cycle_count)
    );

    serial_cfg_reg #(.WIDTH(CFG_W)) u_delay (
        .clk(clk), .rst(rst), .select_in(select_in),
        .sclk(gpio_ctrl[DELAY_CYCLE_CLK_BIT]), .sdata(gpio_ctrl[SDATA_BIT]),
        .value(delay)
    );

    serial_cfg_reg #(.WIDTH(W)) u_mask (
        .clk(clk), .rst(rst), .select_in(select_in),
        .sclk(gpio_ctrl[MASK_CLK_BIT]), .sdata(gpio_ctrl[SDATA_BIT]),
        .value(mask)
    );

    serial_cfg_reg #(.WIDTH(W)) u_lock_wave (
        .clk(clk), .rst(rst), .select_in(select_in),
        .sclk(gpio_ctrl[LOCKING_WAVEFORM_CLK_BIT]), .sdata(gpio_ctrl[SDATA_BIT]),
        .value(lock_wave)
    );

    logic          mux_prev;
    logic          mux_fall_c;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_eff_c;
    logic [CW-1:0] count_eff_c;
    logic          wr_en_c;

    // A 1->0 on mux_sel restarts the load; a beat in that same cycle lands at address 0.
    assign mux_fall_c   = mux_prev & ~mux_sel;
    assign wr_ptr_eff_c = mux_fall_c ? '0 : wr_ptr;
    assign count_eff_c  = mux_fall_c ? '0 : load_count;
    assign s_axis_tready = ~mux_sel & (count_eff_c < CW'(DEPTH));
    assign wr_en_c       = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mux_prev   <= 1'b0;
            wr_ptr     <= '0;
            load_count <= '0;
        end else begin
            mux_prev <= mux_sel;
            if (wr_en_c) begin
                wr_ptr     <= wr_ptr_eff_c + AW'(1);
                load_count <= count_eff_c + CW'(1);
            end else if (mux_fall_c) begin
                wr_ptr     <= '0;
                load_count <= '0;
            end
        end
    end

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  rd_data;
    logic [AW-1:0] rd_ptr_q;

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_eff_c] <= s_axis_tdata;
        end
        rd_data <= mem[rd_ptr_q];
    end

    seq_state_t    state_q, state_d;
    logic [CFG_W-1:0] delay_left_q, delay_left_d;
    logic [CFG_W-1:0] cycles_left_q, cycles_left_d;
    logic          continuous_q, continuous_d;
    logic [AW-1:0] rd_ptr_d;
    logic          last_word_c;
    rd_tag_t       rd_tag_c, rd_tag_q;

    assign last_word_c = ({1'b0, rd_ptr_q} == (load_count - CW'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            delay_left_q  <= '0;
            cycles_left_q <= '0;
            continuous_q  <= 1'b0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            delay_left_q  <= delay_left_d;
            cycles_left_q <= cycles_left_d;
            continuous_q  <= continuous_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        delay_left_d  = delay_left_q;
        cycles_left_d = cycles_left_q;
        continuous_d  = continuous_q;
        rd_ptr_d      = rd_ptr_q;
        rd_tag_c      = '0;

        if (!mux_sel) begin
            state_d  = ST_IDLE;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger_in && (load_count != '0)) begin
                        cycles_left_d = cycle_count;
                        continuous_d  = (cycle_count == '0);
                        rd_ptr_d      = '0;
                        if (delay == '0) begin
                            state_d = ST_PLAY;
                        end else begin
                            state_d      = ST_DELAY;
                            delay_left_d = delay;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_left_q == CFG_W'(1)) begin
                        state_d = ST_PLAY;
                    end else begin
                        delay_left_d = delay_left_q - CFG_W'(1);
                    end
                end
                ST_PLAY: begin
                    rd_tag_c.play = 1'b1;
                    rd_tag_c.mark = (rd_ptr_q == '0);
                    if (last_word_c) begin
                        rd_ptr_d = '0;
                        if (!continuous_q) begin
                            if (cycles_left_q == CFG_W'(1)) begin
                                state_d       = ST_IDLE;
                                rd_tag_c.last = 1'b1;
                            end else begin
                                cycles_left_d = cycles_left_q - CFG_W'(1);
                            end
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output stage: tag tracks the RAM read so marks line up with their words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_tag_q      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            playing       <= 1'b0;
            cycle_mark    <= 1'b0;
            done          <= 1'b0;
        end else begin
            rd_tag_q      <= rd_tag_c;
            m_axis_tdata  <= rd_tag_q.play ? ((rd_data & mask) | (lock_wave & ~mask))
                                           : lock_wave;
            m_axis_tvalid <= 1'b1;
            playing       <= (state_d != ST_IDLE);
            cycle_mark    <= rd_tag_q.play & rd_tag_q.mark;
            done          <= rd_tag_q.last;
        end
    end

endmodule

// File: tb/tb_dac_seq_driver.sv
// Randomised self-checking bench for dac_seq_driver against a cycle-indexed
// playback model derived from trigger time, delay, cycle count and waveform.
module tb_dac_seq_driver;
    import rfsoc_config::*;

    localparam int unsigned W     = 256;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned CW    = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   gpio_ctrl;
    logic          select_in;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          trigger_in;
    logic          playing;
    logic          cycle_mark;
    logic          done;
    logic [CW-1:0] load_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mask_m;
    logic [W-1:0] lock_m;
    logic [W-1:0] wave_q[$];

    dac_seq_driver dut (
        .clk(clk), .rst(rst), .gpio_ctrl(gpio_ctrl), .select_in(select_in),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .trigger_in(trigger_in), .playing(playing), .cycle_mark(cycle_mark),
        .done(done), .load_count(load_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [W-1:0] blend(input logic [W-1:0] w);
        return (w & mask_m) | (lock_m & ~mask_m);
    endfunction

    task automatic ser_write(input int unsigned bit_idx, input logic [W-1:0] val, input int width);
        for (int i = 0; i < width; i++) begin
            gpio_ctrl[SDATA_BIT] = val[i];
            @(posedge clk); #1;
            gpio_ctrl[bit_idx] = 1'b1;
            repeat (3) @(posedge clk);
            #1 gpio_ctrl[bit_idx] = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mux(input logic v);
        ser_write(MUX_SET_CLK_BIT, W'(v), 1);
    endtask

    task automatic load_words();
        s_axis_tvalid = 1'b1;
        foreach (wave_q[i]) begin
            s_axis_tdata = wave_q[i];
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
    endtask

    // n = 0 means continuous. Expected stream is indexed by cycles since the trigger edge.
    task automatic run_check(input int d, input int n, input int cycles, input int retrig_k);
        int len;
        int j;
        bit active;
        len = wave_q.size();
        trigger_in = 1'b1;
        @(posedge clk);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            j = k - (d + 2);
            active = (n == 0) ? (j >= 0) : (j >= 0 && j < n * len);
            check("word", m_axis_tdata, active ? blend(wave_q[j % len]) : lock_m);
            check("cycle_mark", W'(cycle_mark), W'(active && (j % len == 0)));
            check("done", W'(done), W'(n > 0 && j == n * len - 1));
            check("playing", W'(playing), W'((n == 0) || (k < d + n * len)));
            trigger_in = (k == retrig_k);
            @(posedge clk);
        end
        #1 trigger_in = 1'b0;
    endtask

    initial begin
        int d;
        int n;
        int done_cnt;
        rst = 1'b0;
        gpio_ctrl = '0;
        select_in = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        trigger_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_tvalid", W'(m_axis_tvalid), W'(0));
        check("rst_playing", W'(playing), W'(0));
        check("rst_mark", W'(cycle_mark), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_load_count", W'(load_count), W'(0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("tvalid_after_rst", W'(m_axis_tvalid), W'(1));
        check("tready_load_mode", W'(s_axis_tready), W'(1));

        mask_m = {128'h0, {8{16'hFFFF}}};
        lock_m = {16{16'h1111}};
        ser_write(CYCLE_COUNT_CLK_BIT, W'(5), 32);
        ser_write(DELAY_CYCLE_CLK_BIT, W'(3), 32);
        ser_write(MASK_CLK_BIT, mask_m, W);
        ser_write(LOCKING_WAVEFORM_CLK_BIT, lock_m, W);
        check("cfg_cycle_count", W'(dut.cycle_count), W'(5));
        check("cfg_delay", W'(dut.delay), W'(3));
        check("cfg_mask", dut.mask, mask_m);
        check("cfg_lock_wave", dut.lock_wave, lock_m);

        select_in = 1'b0;
        ser_write(MASK_CLK_BIT, rand_word(), 8);
        ser_write(CYCLE_COUNT_CLK_BIT, W'(32'hFFFF_FFFF), 8);
        select_in = 1'b1;
        check("desel_mask", dut.mask, mask_m);
        check("desel_cycle_count", W'(dut.cycle_count), W'(5));
        check("idle_lock_out", m_axis_tdata, lock_m);

        wave_q = '{{16{16'hAAAA}}, {16{16'hBBBB}}, {16{16'hCCCC}}, {16{16'hDDDD}}, {16{16'hEEEE}}};
        load_words();
        check("load_count_5", W'(load_count), W'(5));
        set_mux(1'b1);
        run_check(3, 5, 3 + 25 + 4, 12);

        ser_write(CYCLE_COUNT_CLK_BIT, W'(0), 32);
        ser_write(DELAY_CYCLE_CLK_BIT, W'(0), 32);
        run_check(0, 0, 200, -1);

        // Abort continuous playback by dropping mux_sel.
        gpio_ctrl[SDATA_BIT] = 1'b0;
        @(posedge clk); #1;
        gpio_ctrl[MUX_SET_CLK_BIT] = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (k >= 5) check("abort_lock_out", m_axis_tdata, lock_m);
            if (k == 6) gpio_ctrl[MUX_SET_CLK_BIT] = 1'b0;
            @(posedge clk);
        end
        #1;
        check("abort_no_done", W'(done_cnt), W'(0));
        check("abort_load_count", W'(load_count), W'(0));
        check("abort_playing", W'(playing), W'(0));

        set_mux(1'b1);
        trigger_in = 1'b1;
        @(posedge clk); #1 trigger_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("empty_trig_playing", W'(playing), W'(0));
            check("empty_trig_out", m_axis_tdata, lock_m);
            @(posedge clk);
        end
        #1;

        set_mux(1'b0);
        wave_q.delete();
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            s_axis_tdata = rand_word();
            if (i < DEPTH) wave_q.push_back(s_axis_tdata);
            @(negedge clk);
            if (i >= DEPTH - 1) check("fill_tready", W'(s_axis_tready), W'(i < DEPTH));
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        check("fill_load_count", W'(load_count), W'(DEPTH));
        ser_write(CYCLE_COUNT_CLK_BIT, W'(1), 32);
        d = $urandom_range(0, 6);
        ser_write(DELAY_CYCLE_CLK_BIT, W'(d), 32);
        set_mux(1'b1);
        run_check(d, 1, d + DEPTH + 4, 40);

        set_mux(1'b0);
        wave_q = '{rand_word()};
        load_words();
        check("single_load_count", W'(load_count), W'(1));
        ser_write(CYCLE_COUNT_CLK_BIT, W'(4), 32);
        d = $urandom_range(0, 5);
        ser_write(DELAY_CYCLE_CLK_BIT, W'(d), 32);
        set_mux(1'b1);
        run_check(d, 4, d + 4 + 4, -1);

        mask_m = rand_word();
        ser_write(MASK_CLK_BIT, mask_m, W);
        for (int r = 0; r < 3; r++) begin
            set_mux(1'b0);
            wave_q.delete();
            for (int i = 0; i < int'($urandom_range(2, 8)); i++) wave_q.push_back(rand_word());
            load_words();
            check("rand_load_count", W'(load_count), W'(wave_q.size()));
            n = $urandom_range(1, 3);
            d = $urandom_range(0, 5);
            ser_write(CYCLE_COUNT_CLK_BIT, W'(n), 32);
            ser_write(DELAY_CYCLE_CLK_BIT, W'(d), 32);
            set_mux(1'b1);
            run_check(d, n, d + n * wave_q.size() + 4, 3);
        end

        ser_write(CYCLE_COUNT_CLK_BIT, W'(0), 32);
        trigger_in = 1'b1;
        @(posedge clk); #1 trigger_in = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("pre_rst_playing", W'(playing), W'(1));
        rst = 1'b0;
        #1;
        check("async_rst_tdata", m_axis_tdata, '0);
        check("async_rst_tvalid", W'(m_axis_tvalid), W'(0));
        check("async_rst_playing", W'(playing), W'(0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tvalid", W'(m_axis_tvalid), W'(1));
        check("post_rst_fsm_idle", W'(dut.state_q), W'(ST_IDLE));
        check("post_rst_load_count", W'(load_count), W'(0));
        check("post_rst_tready", W'(s_axis_tready), W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_seq_driver.md
Name: dac_seq_driver

Overview:
- Parametrised successor to the single-buffer DAC driver.
- Stores a multi-word waveform loaded over AXI-Stream into an internal memory of DEPTH words.
- On trigger, plays the waveform after a programmable delay, for N cycles or continuously, blended per bit with a locking waveform through a mask.
- Configured through the serial GPIO interface; sits between the PS DMA stream and one RFDC DAC tile stream.

Parameters:
- SAMPLE_W, 16, bits per DAC sample.
- LANES, 16, samples per AXIS word (word width W = SAMPLE_W*LANES).
- DEPTH, 1024, waveform memory depth in words (power of two).
- CFG_W, 32, width of the cycle-count and delay serial registers.

Ports:
- clk  in  1  system/DAC stream clock.
- rst  in  1  asynchronous active-low reset.
- gpio_ctrl  in  16  serial config bus; bit indices come from rfsoc_config.
- select_in  in  1  gates gpio_ctrl; serial clocks are ignored while 0.
- m_axis_tdata  out  W  DAC sample word.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  ignored (DAC always ready).
- s_axis_tdata  in  W  waveform load word.
- s_axis_tvalid  in  1  load valid.
- s_axis_tready  out  1  high in load mode.
- trigger_in  in  1  single-cycle playback trigger.
- playing  out  1  high in DELAY or PLAY.
- cycle_mark  out  1  one-cycle pulse aligned with the first word of each playback cycle on m_axis.
- done  out  1  one-cycle pulse after the last word of a finite run.
- load_count  out  log2(DEPTH)+1  number of words currently loaded.

Behaviour:
- Reset (rst=0, async) clears all of the following:
  - config registers: mux_sel, cycle_count, delay, mask, lock_wave;
  - write pointer, load_count, FSM (to IDLE) and the output register;
  - m_axis_tdata, m_axis_tvalid, playing, cycle_mark and done go to 0.
- m_axis_tvalid goes to 1 on the first clk after reset release and stays 1.
- Serial config:
  - gpio_ctrl is registered twice in clk. A rising edge is a 0->1 on the synchronised bit while select_in=1.
  - On a rising edge of cycle_count_clk, delay_cycle_clk, mask_clk or locking_waveform_clk, the target register shifts right and sdata enters the MSB.
  - LSB-first transfer of exactly the register width (CFG_W, CFG_W, W, W) therefore lands each bit in place.
  - On a rising edge of mux_set_clk, mux_sel <= sdata.
  - Config registers update in any state. cycle_count and delay are sampled only at trigger acceptance.
- Load mode (mux_sel=0):
  - s_axis_tready=1.
  - Each s_axis_tvalid&tready beat writes mem[wr_ptr], then wr_ptr++ and load_count++.
  - At load_count=DEPTH, tready drops to 0 and further words are refused.
  - A mux_sel 1->0 transition clears wr_ptr and load_count (a new load replaces the old waveform).
  - The FSM is forced to IDLE; an in-progress run is aborted without a done pulse.
- FSM states IDLE, DELAY, PLAY:
  - IDLE -> DELAY when trigger_in=1, mux_sel=1 and load_count>0. The FSM latches delay_left=delay and cycles_left=cycle_count.
  - If delay=0, IDLE goes directly to PLAY on that trigger.
  - DELAY counts down one per clk; at 1 it goes to PLAY.
  - PLAY reads rd_ptr from 0 to load_count-1, one word per clk.
  - At wrap, rd_ptr resets to 0 and cycles_left decrements.
  - After the last word of the cycle where cycles_left=1, the FSM returns to IDLE.
  - cycle_count=0 means continuous playback until mux_sel goes to 0.
  - trigger_in outside IDLE is ignored; there is no retrigger.
- Output datapath:
  - The memory read is registered (1 clk), followed by one output register.
  - Output word = (wave & mask) | (lock_wave & ~mask) for words read in PLAY; lock_wave otherwise.
  - Latency: the first waveform word appears on m_axis exactly delay+2 clk after the clk edge that samples trigger_in.
  - cycle_mark and done travel through the same pipeline, so they align with the words they mark.
- Boundaries:
  - load_count=1 repeats a single word.
  - A trigger with load_count=0 is ignored.
  - A trigger coincident with mux_sel 1->0 is ignored.
  - An s_axis beat coincident with the 1->0 transition is written at address 0.
  - Reset asserted mid-run outputs zeros immediately (async clear).

Decomposition:
- rfsoc_config carries:
  - the gpio_ctrl bit indices (sdata, mux_set_clk, cycle_count_clk, mask_clk, delay_cycle_clk, locking_waveform_clk);
  - a typedef for the FSM state enum;
  - localparams for default widths.
- Sub-module serial_cfg_reg (parameter WIDTH) handles synchroniser, edge detect and shift register. It is instantiated once per config register.
- The memory is inferred inline as a simple dual-port RAM.

Test Plan:
- Serial config: shift cycle_count=5, delay=3, mask = upper 8 lanes 0x0000 / lower 8 lanes 0xFFFF, lock_wave={16{0x1111}} -> internal registers read back exactly. Toggling serial clocks with select_in=0 changes nothing.
- Load words 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.., 0xEEEE.. -> load_count=5. Set mux_sel=1, pulse trigger -> the output sequence is:
  - lock_wave for 5 clk (delay 3 + 2);
  - then 25 masked words (lower lanes wave, upper lanes 0x1111);
  - cycle_mark on words 1, 6, 11, 16, 21;
  - done aligned with word 25, playing drops.
- Retrigger mid-run and trigger with load_count=0 -> no change to the sequence and no run started, respectively.
- cycle_count=0 -> the 5-word pattern repeats for 200 clk without done. Set mux_sel=0 -> the output returns to lock_wave within 2 clk, no done, load_count=0.
- Fill DEPTH+3 words -> load_count=DEPTH and s_axis_tready=0 after word DEPTH. A single-word load (load_count=1) with cycle_count=4 -> 4 identical words.
- Assert rst mid-PLAY -> m_axis_tdata=0, tvalid=0 and playing=0 asynchronously. After release, tvalid=1 and the FSM is in IDLE.
